program_loader: RTL and testbench

Byte-stream writer that fills the CPU's instruction memory, the write side of the 4-bit-address, 16-bit-word instruction store that the multicycle CPU fetches from. It accepts a framed byte stream (count, word bytes, checksum) over a valid/ready handshake and assembles 16-bit instruction words. It issues one write strobe per word. It holds the CPU in reset until a complete load passes its checksum.

---
 rtl/program_loader.sv | 112 +++++++++++
 tb/tb_program_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Framed byte-stream writer for the CPU instruction store: count byte, 2N word
// bytes (high then low), XOR checksum; keeps the CPU in reset until a good load.
module program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [15:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int MAX_WORDS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(START_ADDR);

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHK, DONE, ERROR} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   idx_reg;
  logic [ADDR_WIDTH:0]   idx_next;
  logic [7:0]            hi_reg;
  logic [7:0]            csum_reg;
  logic [7:0]            csum_next;
  logic                  xfer;
  logic                  launch;

  assign in_ready = (state_reg == COUNT) || (state_reg == HI) ||
                    (state_reg == LO)    || (state_reg == CHK);
  assign busy      = in_ready;
  assign xfer      = in_valid && in_ready;
  // start is only honoured when no load is in flight
  assign launch    = start && ((state_reg == IDLE) || (state_reg == DONE) ||
                               (state_reg == ERROR));
  assign idx_next  = idx_reg + (ADDR_WIDTH+1)'(1);
  assign csum_next = csum_reg ^ in_data;
  assign words_loaded = idx_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      idx_reg    <= '0;
      hi_reg     <= '0;
      csum_reg   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (launch) begin
        state_reg <= COUNT;
        csum_reg  <= '0;
        idx_reg   <= '0;
        done      <= 1'b0;
        error     <= 1'b0;
        cpu_hold  <= 1'b1;
      end else if (xfer) begin
        case (state_reg)
          COUNT: begin
            if ((in_data == 8'd0) || (int'(in_data) > MAX_WORDS)) begin
              state_reg <= ERROR;
              error     <= 1'b1;
            end else begin
              count_reg <= (ADDR_WIDTH+1)'(in_data);
              state_reg <= HI;
            end
          end
          HI: begin
            hi_reg    <= in_data;
            csum_reg  <= csum_next;
            state_reg <= LO;
          end
          LO: begin
            // word write is registered here, so it appears one cycle after the low byte
            csum_reg   <= csum_next;
            imem_we    <= 1'b1;
            imem_waddr <= BASE_ADDR + idx_reg[ADDR_WIDTH-1:0];
            imem_wdata <= {hi_reg, in_data};
            idx_reg    <= idx_next;
            state_reg  <= (idx_next == count_reg) ? CHK : HI;
          end
          CHK: begin
            if (in_data == csum_reg) begin
              state_reg <= DONE;
              done      <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state_reg <= ERROR;
              error     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: two instances (start address 0 and 14)
// share one byte stream and are checked against a frame-level reference model.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  logic        in_ready_w     [2];
  logic        imem_we_w      [2];
  logic [3:0]  imem_waddr_w   [2];
  logic [15:0] imem_wdata_w   [2];
  logic        cpu_hold_w     [2];
  logic        busy_w         [2];
  logic        done_w         [2];
  logic        error_w        [2];
  logic [4:0]  words_loaded_w [2];

  logic [19:0] wq0[$];
  logic [19:0] wq1[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    program_loader #(
      .ADDR_WIDTH(4),
      .START_ADDR((gi == 0) ? 0 : 14)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready_w[gi]),
      .imem_we      (imem_we_w[gi]),
      .imem_waddr   (imem_waddr_w[gi]),
      .imem_wdata   (imem_wdata_w[gi]),
      .cpu_hold     (cpu_hold_w[gi]),
      .busy         (busy_w[gi]),
      .done         (done_w[gi]),
      .error        (error_w[gi]),
      .words_loaded (words_loaded_w[gi])
    );
  end

  always @(negedge clk) begin
    if (imem_we_w[0]) wq0.push_back({imem_waddr_w[0], imem_wdata_w[0]});
    if (imem_we_w[1]) wq1.push_back({imem_waddr_w[1], imem_wdata_w[1]});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: which words should land where, and the final status.
  task automatic verify(input logic [7:0] bs[$]);
    int n;
    bit legal;
    bit good;
    logic [7:0] x;
    logic [19:0] got[$];
    n = int'(bs[0]);
    legal = (n != 0) && (n <= 16);
    x = 8'h00;
    good = 1'b0;
    if (legal) begin
      for (int j = 1; j <= 2 * n; j++) x ^= bs[j];
      good = (bs[2 * n + 1] == x);
    end
    for (int d = 0; d < 2; d++) begin
      int sa;
      int nexp;
      sa = (d == 0) ? 0 : 14;
      nexp = legal ? n : 0;
      if (d == 0) got = wq0; else got = wq1;
      check($sformatf("wr_count%0d", d), got.size(), nexp);
      for (int i = 0; i < nexp && i < got.size(); i++) begin
        check($sformatf("wr_addr%0d_%0d", d, i), {28'd0, got[i][19:16]}, (sa + i) % 16);
        check($sformatf("wr_data%0d_%0d", d, i), {16'd0, got[i][15:0]},
              {16'd0, bs[1 + 2 * i], bs[2 + 2 * i]});
      end
      check($sformatf("done%0d", d), done_w[d], good);
      check($sformatf("error%0d", d), error_w[d], !good);
      check($sformatf("cpu_hold%0d", d), cpu_hold_w[d], !good);
      check($sformatf("words_loaded%0d", d), words_loaded_w[d], nexp);
      check($sformatf("busy_end%0d", d), busy_w[d], 1'b0);
      check($sformatf("ready_end%0d", d), in_ready_w[d], 1'b0);
    end
    $display("load n=%0d legal=%0d good=%0d writes=%0d done=%0d error=%0d",
             n, legal, good, wq0.size(), done_w[0], error_w[0]);
  endtask

  task automatic run_load(input logic [7:0] bs[$], input bit gapped);
    int n;
    bit legal;
    wq0.delete();
    wq1.delete();
    n = int'(bs[0]);
    legal = (n != 0) && (n <= 16);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_on_start", cpu_hold_w[0], 1'b1);
    check("busy_on_start", busy_w[0], 1'b1);
    for (int i = 0; i < bs.size(); i++) begin
      if (gapped) begin
        repeat ($urandom_range(1, 3)) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = bs[i];
      if (!in_ready_w[0]) break;
      @(negedge clk);
      if (legal && i >= 2 && (i % 2) == 0 && i <= 2 * n)
        check("we_latency", imem_we_w[0], 1'b1);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    verify(bs);
  endtask

  task automatic gen_load(output logic [7:0] bs[$]);
    int n;
    logic [7:0] x;
    logic [7:0] b;
    bs.delete();
    if ($urandom_range(0, 9) < 8) n = $urandom_range(1, 16);
    else if ($urandom_range(0, 1) == 1) n = 0;
    else n = $urandom_range(17, 255);
    bs.push_back(8'(n));
    if (n >= 1 && n <= 16) begin
      x = 8'h00;
      for (int j = 0; j < 2 * n; j++) begin
        b = 8'($urandom);
        bs.push_back(b);
        x ^= b;
      end
      if ($urandom_range(0, 9) < 7) bs.push_back(x);
      else bs.push_back(x ^ 8'($urandom_range(1, 255)));
    end else begin
      for (int j = 0; j < 4; j++) bs.push_back(8'($urandom));
    end
  endtask

  initial begin
    logic [7:0] bs[$];
    logic [7:0] x;

    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_hold", cpu_hold_w[d], 1'b1);
      check("rst_ready", in_ready_w[d], 1'b0);
      check("rst_we", imem_we_w[d], 1'b0);
      check("rst_busy", busy_w[d], 1'b0);
      check("rst_done", done_w[d], 1'b0);
      check("rst_error", error_w[d], 1'b0);
      check("rst_words", words_loaded_w[d], 5'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    bs = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load(bs, 1'b0);
    bs = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_load(bs, 1'b0);
    bs = '{8'h00, 8'h12, 8'h34};
    run_load(bs, 1'b0);
    bs = '{8'h11, 8'h12, 8'h34};
    run_load(bs, 1'b0);
    bs = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load(bs, 1'b1);

    bs = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    x = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66;
    bs.push_back(x);
    run_load(bs, 1'b0);

    // start coinciding with reset must resolve to reset
    start = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    check("startrst_busy", busy_w[0], 1'b0);
    check("startrst_done", done_w[0], 1'b0);
    check("startrst_hold", cpu_hold_w[0], 1'b1);
    $display("start+reset: busy=%0d hold=%0d", busy_w[0], cpu_hold_w[0]);

    // abort after the first word has been written
    wq0.delete();
    wq1.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bs = '{8'h03, 8'h12, 8'h34};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = bs[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("abort_we", imem_we_w[0], 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_hold", cpu_hold_w[0], 1'b1);
    check("abort_busy", busy_w[0], 1'b0);
    check("abort_words", words_loaded_w[0], 5'd0);
    check("abort_waddr", imem_waddr_w[0], 4'd0);
    check("abort_wdata", imem_wdata_w[0], 16'd0);
    check("abort_error", error_w[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'h56 + 8'(i);
      @(negedge clk);
      check("abort_ready", in_ready_w[0], 1'b0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_wrcount", wq0.size(), 1);
    if (wq0.size() > 0) check("abort_wr", wq0[0], {4'd0, 16'h1234});
    $display("abort: writes=%0d hold=%0d", wq0.size(), cpu_hold_w[0]);

    for (int t = 0; t < 30; t++) begin
      gen_load(bs);
      run_load(bs, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
